// File: rtl/box_field.sv
`default_nettype none
// ============================================================================
// Module   : box_field
// Purpose  : Multi-box renderer and frame-synchronous mover; defining
//            BOX_BOUNCE_EN adds autonomous bouncing motion (mode = 1).
// Revision : 1.0
// ============================================================================
module box_field #(
    parameter int          NUM_BOXES = 4,
    parameter int          BOX_W     = 100,
    parameter int          BOX_H     = 100,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          STEP      = 1,
    parameter logic [23:0] BG_RGB    = 24'h505050
) (
    input  logic        clk_25mhz,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        vsync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic        mode,
    output logic [23:0] rgb,
    output logic [2:0]  sel,
    output logic        busy
);

    localparam logic signed [10:0] X_MAX    = 11'(H_ACTIVE - BOX_W);
    localparam logic signed [10:0] Y_MAX    = 11'(V_ACTIVE - BOX_H);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic [2:0]         LAST_IDX = 3'(NUM_BOXES - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    state_t      state_q;
    logic        vsync_q;
    logic        btn_sel_q;
    logic        sel_pend_q;
    logic [2:0]  idx_q;
    logic [2:0]  sel_q;
    logic [3:0]  btn_q;        // {left, right, up, down}
    logic [9:0]  bx_q [NUM_BOXES];
    logic [9:0]  by_q [NUM_BOXES];
    logic [23:0] rgb_q;

`ifdef BOX_BOUNCE_EN
    logic [NUM_BOXES-1:0] dx_q;
    logic [NUM_BOXES-1:0] dy_q;
    logic                 bounce_q;
    logic                 cur_dx;
    logic                 cur_dy;
    logic                 ndx_d;
    logic                 ndy_d;
`else
    logic mode_unused;
    assign mode_unused = mode;
`endif

    logic tick;
    logic sel_rise;
    assign tick     = vsync & ~vsync_q;
    assign sel_rise = btn_sel & ~btn_sel_q;

    // Fetch the box addressed by the update counter.
    logic signed [10:0] cur_x;
    logic signed [10:0] cur_y;
    always_comb begin
        cur_x = '0;
        cur_y = '0;
`ifdef BOX_BOUNCE_EN
        cur_dx = 1'b1;
        cur_dy = 1'b1;
`endif
        for (int k = 0; k < NUM_BOXES; k++) begin
            if (idx_q == 3'(k)) begin
                cur_x = {1'b0, bx_q[k]};
                cur_y = {1'b0, by_q[k]};
`ifdef BOX_BOUNCE_EN
                cur_dx = dx_q[k];
                cur_dy = dy_q[k];
`endif
            end
        end
    end

    logic signed [10:0] step_x;
    logic signed [10:0] step_y;
    logic signed [10:0] sum_x;
    logic signed [10:0] sum_y;
    logic [9:0]         nx_d;
    logic [9:0]         ny_d;
    logic               move_en;
    always_comb begin
        step_x  = '0;
        step_y  = '0;
        move_en = (idx_q == sel_q);
        if (btn_q[2]) step_x = step_x + STEP_S;
        if (btn_q[3]) step_x = step_x - STEP_S;
        if (btn_q[0]) step_y = step_y + STEP_S;
        if (btn_q[1]) step_y = step_y - STEP_S;
`ifdef BOX_BOUNCE_EN
        if (bounce_q) begin
            move_en = 1'b1;
            step_x  = cur_dx ? STEP_S : -STEP_S;
            step_y  = cur_dy ? STEP_S : -STEP_S;
        end
`endif
        sum_x = cur_x + step_x;
        sum_y = cur_y + step_y;
        nx_d  = sum_x[9:0];
        ny_d  = sum_y[9:0];
        if (sum_x < 11'sd0)      nx_d = '0;
        else if (sum_x > X_MAX)  nx_d = 10'(X_MAX);
        if (sum_y < 11'sd0)      ny_d = '0;
        else if (sum_y > Y_MAX)  ny_d = 10'(Y_MAX);
`ifdef BOX_BOUNCE_EN
        ndx_d = cur_dx;
        ndy_d = cur_dy;
        if (bounce_q && (sum_x < 11'sd0 || sum_x > X_MAX)) ndx_d = ~cur_dx;
        if (bounce_q && (sum_y < 11'sd0 || sum_y > Y_MAX)) ndy_d = ~cur_dy;
`endif
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b0;
            btn_sel_q  <= 1'b0;
            sel_pend_q <= 1'b0;
            idx_q      <= '0;
            sel_q      <= '0;
            btn_q      <= '0;
            for (int k = 0; k < NUM_BOXES; k++) begin
                bx_q[k] <= 10'((40 * k) % (H_ACTIVE - BOX_W + 1));
                by_q[k] <= 10'((30 * k) % (V_ACTIVE - BOX_H + 1));
            end
`ifdef BOX_BOUNCE_EN
            bounce_q <= 1'b0;
            for (int k = 0; k < NUM_BOXES; k++) begin
                dx_q[k] <= (k % 2 == 0);
                dy_q[k] <= 1'b1;
            end
`endif
        end else begin
            vsync_q   <= vsync;
            btn_sel_q <= btn_sel;
            if (sel_rise) sel_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q    <= S_UPDATE;
                        idx_q      <= '0;
                        btn_q      <= {btn_left, btn_right, btn_up, btn_down};
                        sel_pend_q <= 1'b0;
`ifdef BOX_BOUNCE_EN
                        bounce_q   <= mode;
`endif
                        // A press coinciding with the tick counts for this frame.
                        if (sel_pend_q || sel_rise)
                            sel_q <= (sel_q == LAST_IDX) ? 3'd0 : sel_q + 3'd1;
                    end
                end
                S_UPDATE: begin
                    for (int k = 0; k < NUM_BOXES; k++) begin
                        if (move_en && idx_q == 3'(k)) begin
                            bx_q[k] <= nx_d;
                            by_q[k] <= ny_d;
`ifdef BOX_BOUNCE_EN
                            dx_q[k] <= ndx_d;
                            dy_q[k] <= ndy_d;
`endif
                        end
                    end
                    if (idx_q == LAST_IDX) state_q <= S_IDLE;
                    else                   idx_q   <= idx_q + 3'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    function automatic logic [23:0] palette(input logic [1:0] k);
        case (k)
            2'd0:    return 24'hFF7F00;
            2'd1:    return 24'h00C0FF;
            2'd2:    return 24'h40FF40;
            default: return 24'hFF40C0;
        endcase
    endfunction

    // Walk from the highest index down so the lowest covering box wins.
    logic [23:0] pix_d;
    logic [10:0] xe, ye, x0, x1, y0, y1;
    always_comb begin
        pix_d = BG_RGB;
        xe    = {1'b0, x};
        ye    = {1'b0, y};
        x0    = '0;
        x1    = '0;
        y0    = '0;
        y1    = '0;
        for (int k = NUM_BOXES - 1; k >= 0; k--) begin
            x0 = {1'b0, bx_q[k]};
            y0 = {1'b0, by_q[k]};
            x1 = x0 + 11'(BOX_W);
            y1 = y0 + 11'(BOX_H);
            if (xe >= x0 && xe < x1 && ye >= y0 && ye < y1) begin
                pix_d = palette(2'(k));
                if (sel_q == 3'(k) &&
                    (xe == x0 || xe == x1 - 11'd1 || ye == y0 || ye == y1 - 11'd1))
                    pix_d = 24'hFFFFFF;
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) rgb_q <= '0;
        else        rgb_q <= pix_d;
    end

    assign rgb  = rgb_q;
    assign sel  = sel_q;
    assign busy = (state_q == S_UPDATE);

endmodule
`default_nettype wire

// File: tb/tb_box_field.sv
`default_nettype none
// tb_box_field: directed frames and pixel probes for box_field, with a
// frame-level model of positions/selection checked against the DUT each cycle.
module tb_box_field;

    localparam int          N    = 4;
    localparam int          BW   = 100;
    localparam int          BH   = 100;
    localparam int          HA   = 640;
    localparam int          VA   = 480;
    localparam int          STP  = 1;
    localparam logic [23:0] BG   = 24'h505050;
    localparam int          XMAX = HA - BW;
    localparam int          YMAX = VA - BH;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x     = '0;
    logic [9:0]  y     = '0;
    logic        vsync = 1'b0;
    logic        bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, bs = 1'b0;
    logic        mode  = 1'b0;
    logic [23:0] rgb;
    logic [2:0]  sel;
    logic        busy;

    box_field #(
        .NUM_BOXES(N), .BOX_W(BW), .BOX_H(BH), .H_ACTIVE(HA),
        .V_ACTIVE(VA), .STEP(STP), .BG_RGB(BG)
    ) dut (
        .clk_25mhz(clk), .rst_n(rst_n), .x(x), .y(y), .vsync(vsync),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .btn_sel(bs), .mode(mode), .rgb(rgb), .sel(sel), .busy(busy)
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: box positions, selection, busy window.
    int mbx [N];
    int mby [N];
    int msel, mcnt, px, py;
    bit mpend, msel_prev, mvs_prev, rgb_valid, chk_en;
    bit m_rise, m_tick, m_acc;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [23:0] mcol(input int xx, input int yy);
        for (int k = 0; k < N; k++) begin
            if (xx >= mbx[k] && xx < mbx[k] + BW && yy >= mby[k] && yy < mby[k] + BH) begin
                if (k == msel && (xx == mbx[k] || xx == mbx[k] + BW - 1 ||
                                  yy == mby[k] || yy == mby[k] + BH - 1))
                    return 24'hFFFFFF;
                case (k % 4)
                    0:       return 24'hFF7F00;
                    1:       return 24'h00C0FF;
                    2:       return 24'h40FF40;
                    default: return 24'hFF40C0;
                endcase
            end
        end
        return BG;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                mbx[k] = (40 * k) % (XMAX + 1);
                mby[k] = (30 * k) % (YMAX + 1);
            end
            msel = 0; mcnt = 0; mpend = 0; msel_prev = 0; mvs_prev = 0; rgb_valid = 0;
        end else begin
            m_rise    = bs && !msel_prev;
            m_tick    = vsync && !mvs_prev;
            m_acc     = 0;
            rgb_valid = chk_en;
            px        = int'(x);
            py        = int'(y);
            if (mcnt > 1) mcnt--;
            else if (m_tick) begin
                m_acc = 1;
                mcnt  = N;
                if (mpend || m_rise) msel = (msel + 1) % N;
                mpend = 0;
                mbx[msel] = clampi(mbx[msel] + STP * (int'(br) - int'(bl)), 0, XMAX);
                mby[msel] = clampi(mby[msel] + STP * (int'(bd) - int'(bu)), 0, YMAX);
            end else mcnt = 0;
            if (m_rise && !m_acc) mpend = 1;
            msel_prev = bs;
            mvs_prev  = vsync;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("sel", 32'(sel), 32'(msel));
            chk("busy", 32'(busy), 32'(mcnt > 0));
            if (rgb_valid) chk("rgb_model", 32'(rgb), 32'(mcol(px, py)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int xx, input int yy, input logic [23:0] exp);
        x = 10'(xx);
        y = 10'(yy);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("pix(%0d,%0d)", xx, yy), 32'(rgb), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic l, input logic r, input logic u, input logic d);
        chk_en = 0;
        bl = l; br = r; bu = u; bd = d;
        step(1);
        vsync = 1'b1;
        step(N + 4);
        vsync = 1'b0;
        bl = 0; br = 0; bu = 0; bd = 0;
        step(2);
        chk_en = 1;
    endtask

    task automatic sel_pulse();
        bs = 1'b1;
        step(2);
        bs = 1'b0;
        step(1);
        frame(0, 0, 0, 0);
    endtask

    initial begin
        chk_en = 0;
        step(3);
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        chk_en = 1;
        step(1);

        // Reset layout: box0 (0,0) selected, box1 (40,30), box2 (80,60), box3 (120,90).
        probe(0, 0, 24'hFFFFFF);
        probe(50, 50, 24'hFF7F00);
        probe(100, 50, 24'h00C0FF);
        probe(140, 60, 24'h40FF40);
        probe(179, 100, 24'h40FF40);
        probe(180, 100, 24'hFF40C0);
        probe(50, 100, 24'h00C0FF);
        probe(300, 300, BG);

        repeat (3) frame(0, 1, 0, 0);
        probe(3, 50, 24'hFFFFFF);
        probe(2, 50, BG);
        probe(102, 50, 24'hFFFFFF);
        probe(103, 50, 24'h00C0FF);

        repeat (3) frame(1, 0, 0, 0);
        probe(0, 50, 24'hFFFFFF);
        repeat (2) frame(1, 0, 0, 0);
        probe(0, 50, 24'hFFFFFF);
        probe(1, 50, 24'hFF7F00);

        repeat (545) frame(0, 1, 0, 0);
        probe(539, 50, BG);
        probe(540, 50, 24'hFFFFFF);
        probe(560, 50, 24'hFF7F00);
        probe(639, 50, 24'hFFFFFF);

        frame(1, 0, 0, 1);
        probe(539, 1, 24'hFFFFFF);
        probe(539, 0, BG);
        frame(1, 1, 1, 1);
        probe(539, 1, 24'hFFFFFF);
        frame(0, 1, 1, 0);
        probe(540, 0, 24'hFFFFFF);
        probe(539, 50, BG);

        sel_pulse();
        sel_pulse();
        chk("sel_two_pulses", 32'(sel), 32'd2);
        probe(179, 159, 24'hFFFFFF);
        probe(178, 158, 24'h40FF40);

        bs = 1'b1;
        repeat (5) frame(0, 0, 0, 0);
        bs = 1'b0;
        step(2);
        chk("sel_held", 32'(sel), 32'd3);
        probe(219, 189, 24'hFFFFFF);
        probe(219, 190, BG);

        sel_pulse();
        chk("sel_wrap", 32'(sel), 32'd0);
        probe(540, 0, 24'hFFFFFF);

        // Reset while the update FSM is mid-frame.
        sel_pulse();
        chk_en = 0;
        step(1);
        vsync = 1'b1;
        step(3);
        chk("busy_before_rst", 32'(busy), 32'h1);
        rst_n = 1'b0;
        vsync = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_sel", 32'(sel), 32'h0);
        chk("midrst_rgb", 32'(rgb), 32'h0);
        step(2);
        rst_n = 1'b1;
        chk_en = 1;
        step(1);
        probe(0, 0, 24'hFFFFFF);
        probe(140, 60, 24'h40FF40);
        probe(560, 50, BG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/box_field.md
# box_field

Parametrised multi-box renderer and frame-synchronous mover that sits between the button inputs and `digital_video`. It holds the positions of `NUM_BOXES` axis-aligned boxes, updates them once per frame on the rising edge of vsync, and turns the current pixel coordinate into a 24-bit colour. It runs entirely in the `clk_25mhz` domain and samples vsync rather than being clocked by it. A compile-time option adds autonomous bouncing motion.

## Interface
Parameters:
- `NUM_BOXES`, 4: number of boxes, 1..8.
- `BOX_W`, 100: box width in pixels.
- `BOX_H`, 100: box height in pixels.
- `H_ACTIVE`, 640: visible width.
- `V_ACTIVE`, 480: visible height.
- `STEP`, 1: pixels moved per frame.
- `BG_RGB`, 24'h505050: background colour.

Ports:
- `clk_25mhz`  in  1  pixel clock; one clock domain, all logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x`  in  10  current pixel column from `digital_video`.
- `y`  in  10  current pixel row from `digital_video`.
- `vsync`  in  1  vsync level from `digital_video`, synchronous to `clk_25mhz`.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  manual motion buttons, active-high.
- `btn_sel`  in  1  select next box, active-high.
- `mode`  in  1  0 = manual, 1 = bounce. Ignored unless `BOX_BOUNCE_EN` is defined.
- `rgb`  out  24  {R,G,B} pixel colour, registered.
- `sel`  out  3  index of the selected box.
- `busy`  out  1  high while the frame-update FSM is running.

## Operation
- **Vsync edge detect:** `vsync_q` register. A frame tick is `vsync & ~vsync_q`.
- **FSM states:** IDLE and UPDATE.
  - IDLE → UPDATE on a frame tick. The index counter `i` is set to 0, and buttons are latched into `btn_q`.
  - UPDATE processes box `i` in one cycle, then increments `i`.
  - UPDATE → IDLE after box `NUM_BOXES-1`.
  - Frame ticks that arrive during UPDATE are ignored.
  - `busy` = (state == UPDATE).
- **Manual motion (selected box only):**
  - x changes by +`STEP` for right and −`STEP` for left. Both pressed gives no x motion.
  - y behaves the same way with up and down. Diagonal motion is allowed.
  - Results clamp to x in [0, `H_ACTIVE-BOX_W`] and y in [0, `V_ACTIVE-BOX_H`]. Arithmetic is 11-bit signed, so there is no wrap-around.
- **Select:**
  - A rising edge of `btn_sel` between two frame ticks advances `sel` by 1 modulo `NUM_BOXES` at the next tick.
  - A held button advances once only.
- **Hit test:** box k covers `x >= bx_k && x < bx_k+BOX_W && y >= by_k && y < by_k+BOX_H`. The edges are half-open.
- **Colour:**
  - Where boxes overlap, the lowest covering index wins.
  - Palette by `k mod 4`: FF7F00, 00C0FF, 40FF40, FF40C0.
  - The 1-pixel perimeter of the selected box (first or last row or column inside it) is FFFFFF.
  - Pixels not covered by any box are `BG_RGB`.
- **Reset state:**
  - `bx_k = (40*k) mod (H_ACTIVE-BOX_W+1)`, `by_k = (30*k) mod (V_ACTIVE-BOX_H+1)`.
  - `sel` = 0, `rgb` = 0, `busy` = 0, state = IDLE.
  - Direction flags: dx = +1 for even k and −1 for odd k; dy = +1 for all k.

## Timing
- `rgb` is valid 1 clock after `x`/`y`. The hit test is combinational and feeds the output register.
- Position updates complete `NUM_BOXES` cycles after the vsync rising edge. This always falls in vertical blanking.
- Asserting `rst_n` low at any time, including mid-UPDATE, immediately restores all reset values.
- Button inputs are sampled only at the frame tick. This gives roughly 60 Hz natural debounce.

## Configuration
- **`BOX_BOUNCE_EN` defined:** when `mode` = 1, every box moves by `STEP`·(dx, dy) each frame.
  - If the next position passes a bound, the position is clamped to that bound and the direction flag is inverted in the same cycle.
  - Motion buttons are ignored; `btn_sel` still works.
  - When `mode` = 0, behaviour is manual.
- **`BOX_BOUNCE_EN` undefined:** there is no direction state and `mode` is ignored. The block is always manual.

## Test plan
- Reset with NUM_BOXES=4 → box 2 at (80,60); `sel`=0; `rgb`=0; then pixel (0,0) → FF7F00 perimeter FFFFFF (box 0 selected, at origin).
- Hold `btn_right` for 3 frames → bx_0 = 3; `busy` high for exactly 4 cycles after each vsync rise.
- bx_0 = 0, hold `btn_left` for 2 frames → bx_0 stays 0. bx_0 = 540, hold right → stays 540.
- Pulse `btn_sel` twice across 2 frames → `sel`=2; hold `btn_sel` for 5 frames → `sel` advances by 1 only.
- Overlap: boxes 0 and 1 both cover (50,50) → `rgb` one clock later = box 0 colour; boundary pixel x = bx+100 → not covered.
- With `BOX_BOUNCE_EN`, `mode`=1, box 0 at x=539 with dx=+1 and STEP=2 → x = 540 and dx = −1; next frame x = 538.
